// File: rtl/button_pkg.sv
// button_pkg: shared FSM state type and width helper for the debounced button encoder.
package button_pkg;

    typedef enum logic {ST_IDLE, ST_HELD} state_t;

    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser plus persistence counter for one raw button.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/button_encoder_debounced.sv
// button_encoder_debounced: debounced N-button priority encoder with press strobe and held/multi status.
// Optional auto-repeat of key_valid while held is enabled by defining BUTTON_AUTO_REPEAT_EN.
module button_encoder_debounced
    import button_pkg::*;
#(
    parameter  int N_BUTTONS       = 4,
    parameter  int DEBOUNCE_CYCLES = 3,
`ifdef BUTTON_AUTO_REPEAT_EN
    parameter  int REPEAT_CYCLES   = 8,
`endif
    localparam int CODE_W          = clog2(N_BUTTONS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] button_in,
    output logic [CODE_W-1:0]    key_code,
    output logic                 key_valid,
    output logic                 key_held,
    output logic                 multi_press
);
    logic [N_BUTTONS-1:0] deb;
    logic [CODE_W-1:0]    winner;
    logic                 accept, repeat_hit;
    state_t               state, state_d;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_deb
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clock (clock),
            .reset (reset),
            .raw   (button_in[i]),
            .stable(deb[i])
        );
    end

    // Scan downwards so the lowest set index is the last (winning) assignment.
    always_comb begin
        winner = '0;
        for (int i = N_BUTTONS - 1; i >= 0; i--)
            if (deb[i]) winner = CODE_W'(i);
    end

    always_comb begin
        accept   = (state == ST_IDLE) && (deb != '0);
        state_d  = accept ? ST_HELD : ((state == ST_HELD) && (deb == '0)) ? ST_IDLE : state;
        key_held = (state == ST_HELD);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_d;
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    logic [RW-1:0] rpt;

    assign repeat_hit = (state == ST_HELD) && (state_d == ST_HELD) && (rpt == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rpt <= '0;
        else        rpt <= (state_d != ST_HELD || accept || repeat_hit) ? '0 : rpt + 1'b1;
    end
`else
    assign repeat_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_code    <= '0;
            key_valid   <= 1'b0;
            multi_press <= 1'b0;
        end else begin
            key_code    <= accept ? winner : key_code;
            key_valid   <= accept | repeat_hit;
            multi_press <= $countones(deb) > 1;
        end
    end
endmodule
